jk_updown_counter: RTL and testbench

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

---
 rtl/jk_counter_pkg.sv | 20 ++
 rtl/jk_counter_cell.sv | 24 ++
 rtl/jk_updown_counter.sv | 88 ++++++++
 tb/tb_jk_updown_counter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-flip-flop based up/down counter.
// Holds the direction encoding and the load saturation helper.
package jk_counter_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    localparam int unsigned SAT_W = 16;

    // Clamp a load value to the terminal count.
    function automatic logic [SAT_W-1:0] saturate(
        input logic [SAT_W-1:0] value,
        input logic [SAT_W-1:0] max_value
    );
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/jk_counter_cell.sv
// Single JK flip-flop with synchronous active-high reset.
// J/K encoding: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_updown_counter.sv
// Up/down counter with terminal value MAX_COUNT built from one JK cell per bit.
// Load and wrap force each cell to a target value; normal counting toggles bits.
module jk_updown_counter
    import jk_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

    logic             count_up;
    logic             above_max;
    logic             wrap_now;
    logic             force_val;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    assign count_up  = (up_dn == DIR_UP);
    assign above_max = (Q > MAX_Q);
    assign tc        = count_up ? (Q == MAX_Q) : (Q == '0);

    // An out-of-range Q is treated as a wrap in either direction.
    assign wrap_now  = en && !load &&
                       (count_up ? (Q >= MAX_Q) : ((Q == '0) || above_max));
    assign force_val = load || wrap_now;
    assign sat_val   = WIDTH'(saturate(SAT_W'(load_val), SAT_W'(MAX_COUNT)));
    assign target    = load ? sat_val : (count_up ? '0 : MAX_Q);

    always_comb begin
        logic up_run;
        logic dn_run;
        toggle = '0;
        up_run = 1'b1;
        dn_run = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            toggle[i] = count_up ? up_run : dn_run;
            up_run    = up_run & Q[i];
            dn_run    = dn_run & ~Q[i];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (force_val) begin
                j[i] = target[i];
                k[i] = ~target[i];
            end else begin
                j[i] = en & toggle[i];
                k[i] = en & toggle[i];
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j[g]),
            .k     (k[g]),
            .q     (Q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_now;
        end
    end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Scoreboard bench for jk_updown_counter: a WIDTH=4/MAX_COUNT=9 instance and a
// WIDTH=3 default-terminal instance, driven by directed vectors.
module tb_jk_updown_counter;

    typedef struct {
        string       name;
        int unsigned dut;
        logic [3:0]  q;
        logic        wrap;
        logic        tc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset = 1'b1, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
    logic [3:0] a_lv = '0;
    logic [3:0] a_q;
    logic       a_tc, a_wrap;

    logic       b_reset = 1'b1, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0;
    logic [2:0] b_lv = '0;
    logic [2:0] b_q;
    logic       b_tc, b_wrap;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    jk_updown_counter #(.WIDTH(4), .MAX_COUNT(9)) dut_a (
        .clk(clk), .reset(a_reset), .en(a_en), .up_dn(a_up), .load(a_load),
        .load_val(a_lv), .Q(a_q), .tc(a_tc), .wrap(a_wrap)
    );

    jk_updown_counter #(.WIDTH(3)) dut_b (
        .clk(clk), .reset(b_reset), .en(b_en), .up_dn(b_up), .load(b_load),
        .load_val(b_lv), .Q(b_q), .tc(b_tc), .wrap(b_wrap)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: outputs settle one step after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.dut == 0) begin
                    check({e.name, ".Q"},    a_q,           e.q);
                    check({e.name, ".wrap"}, {3'b0, a_wrap}, {3'b0, e.wrap});
                    check({e.name, ".tc"},   {3'b0, a_tc},   {3'b0, e.tc});
                end else begin
                    check({e.name, ".Q"},    {1'b0, b_q},   e.q);
                    check({e.name, ".wrap"}, {3'b0, b_wrap}, {3'b0, e.wrap});
                    check({e.name, ".tc"},   {3'b0, b_tc},   {3'b0, e.tc});
                end
            end
        end
    end

    task automatic step_a(input string name, input logic rst, input logic en, input logic up,
                          input logic ld, input logic [3:0] lv,
                          input logic [3:0] eq, input logic ew, input logic etc);
        exp_t e;
        @(negedge clk);
        a_reset = rst; a_en = en; a_up = up; a_load = ld; a_lv = lv;
        e.name = name; e.dut = 0; e.q = eq; e.wrap = ew; e.tc = etc;
        exp_q.push_back(e);
    endtask

    task automatic step_b(input string name, input logic rst, input logic en, input logic up,
                          input logic ld, input logic [2:0] lv,
                          input logic [3:0] eq, input logic ew, input logic etc);
        exp_t e;
        @(negedge clk);
        b_reset = rst; b_en = en; b_up = up; b_load = ld; b_lv = lv;
        e.name = name; e.dut = 1; e.q = eq; e.wrap = ew; e.tc = etc;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [3:0] eq;
        int unsigned drain;

        step_a("a_reset", 1, 0, 1, 0, 4'd0, 4'd0, 0, 0);

        // Up count 1..9,0,1,2 with terminal 9.
        for (int unsigned i = 1; i <= 12; i++) begin
            eq = 4'(i % 10);
            step_a("a_up", 0, 1, 1, 0, 4'd0, eq, eq == 4'd0, eq == 4'd9);
        end

        // Load 3 then count down through the 0 -> 9 wrap.
        step_a("a_load3",  0, 0, 0, 1, 4'd3, 4'd3, 0, 0);
        step_a("a_dn2",    0, 1, 0, 0, 4'd0, 4'd2, 0, 0);
        step_a("a_dn1",    0, 1, 0, 0, 4'd0, 4'd1, 0, 0);
        step_a("a_dn0",    0, 1, 0, 0, 4'd0, 4'd0, 0, 1);
        step_a("a_dn9",    0, 1, 0, 0, 4'd0, 4'd9, 1, 0);
        step_a("a_dn8",    0, 1, 0, 0, 4'd0, 4'd8, 0, 0);

        // Saturating load; load beats enable even at the wrap point.
        step_a("a_ld14",   0, 1, 1, 1, 4'd14, 4'd9, 0, 1);
        step_a("a_ld2_en", 0, 1, 1, 1, 4'd2,  4'd2, 0, 0);
        step_a("a_ld6",    0, 0, 1, 1, 4'd6,  4'd6, 0, 0);

        // Reset wins over load and enable, counting resumes from 0.
        step_a("a_rst_mid", 1, 1, 1, 1, 4'd4, 4'd0, 0, 0);
        step_a("a_resume1", 0, 1, 1, 0, 4'd0, 4'd1, 0, 0);
        step_a("a_resume2", 0, 1, 1, 0, 4'd0, 4'd2, 0, 0);

        // Direction flip at 0: tc follows up_dn before the edge.
        step_a("a_ld0",    0, 0, 1, 1, 4'd0, 4'd0, 0, 0);
        step_a("a_flip",   0, 1, 0, 0, 4'd0, 4'd9, 1, 0);
        #1;
        check("a_tc_comb", {3'b0, a_tc}, 4'd1);
        step_a("a_hold",   0, 0, 0, 0, 4'd0, 4'd9, 0, 0);
        step_a("a_flipup", 0, 1, 1, 0, 4'd0, 4'd0, 1, 0);
        step_a("a_idle",   0, 0, 1, 0, 4'd0, 4'd0, 0, 0);

        // Three-bit counter with the default terminal of 7.
        step_b("b_reset",  1, 0, 1, 0, 3'd0, 4'd0, 0, 0);
        step_b("b_ld5",    0, 0, 1, 1, 3'd5, 4'd5, 0, 0);
        step_b("b_en1",    0, 1, 1, 0, 3'd0, 4'd6, 0, 0);
        step_b("b_en0",    0, 0, 1, 0, 3'd0, 4'd6, 0, 0);
        step_b("b_en1b",   0, 1, 1, 0, 3'd0, 4'd7, 0, 1);
        step_b("b_en1c",   0, 1, 1, 0, 3'd0, 4'd0, 1, 0);
        step_b("b_idle",   0, 0, 1, 0, 3'd0, 4'd0, 0, 0);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
